// File: rtl/gregac_tiny_nn.sv
`default_nettype none
// ============================================================================
// Module      : gregac_tiny_nn
// Description : Tiny int8 single-neuron accelerator (TinyTapeout user block).
//               Holds N signed weights, N signed inputs and a bias, and
//               computes y = act((sum w[i]*x[i] + (b <<< SHIFT)) >>> SHIFT)
//               with a serial MAC, one product per clock.
//               Optional feature macro: TINY_NN_RELU_EN (ReLU after
//               saturation; default build outputs the raw saturated value).
// Revision    : 1.0 - initial release
// ============================================================================
module gregac_tiny_nn #(
    parameter int N     = 8,
    parameter int SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int                 c_PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(N - 1);

    localparam logic [2:0] c_OP_LOAD_W    = 3'd1;
    localparam logic [2:0] c_OP_LOAD_X    = 3'd2;
    localparam logic [2:0] c_OP_LOAD_B    = 3'd3;
    localparam logic [2:0] c_OP_START     = 3'd4;
    localparam logic [2:0] c_OP_CLEAR_PTR = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                r_state;
    logic signed [7:0]     r_w [N];
    logic signed [7:0]     r_x [N];
    logic signed [7:0]     r_bias;
    logic [c_PTR_W-1:0]    r_w_ptr;
    logic [c_PTR_W-1:0]    r_x_ptr;
    logic [c_PTR_W-1:0]    r_idx;
    logic signed [23:0]    r_acc;
    logic [7:0]            r_result;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sat;

    logic                  w_cmd;
    logic [2:0]            w_op;
    logic signed [15:0]    w_prod;
    logic signed [23:0]    w_prod_ext;
    logic signed [23:0]    w_acc_init;
    logic signed [23:0]    w_shifted;
    logic                  w_hi;
    logic                  w_lo;
    logic signed [7:0]     w_sat_val;
    logic [7:0]            w_final;
    logic                  w_unused;

    assign w_cmd    = ena & uio_in[3];
    assign w_op     = uio_in[2:0];
    assign w_unused = ^uio_in[7:4];

    // Datapath: current product, bias preload, requantize and clamp
    always_comb begin
        w_prod     = r_w[r_idx] * r_x[r_idx];
        w_prod_ext = {{8{w_prod[15]}}, w_prod};
        w_acc_init = {{16{r_bias[7]}}, r_bias} <<< SHIFT;
        w_shifted  = r_acc >>> SHIFT;
        w_hi       = (w_shifted > 24'sd127);
        w_lo       = (w_shifted < -24'sd128);
        if (w_hi) begin
            w_sat_val = 8'sd127;
        end else if (w_lo) begin
            w_sat_val = -8'sd128;
        end else begin
            w_sat_val = w_shifted[7:0];
        end
`ifdef TINY_NN_RELU_EN
        w_final = w_sat_val[7] ? 8'd0 : w_sat_val;
`else
        w_final = w_sat_val;
`endif
    end

    // Command decode, operand storage and the IDLE->MAC->OUT sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                r_w[i] <= '0;
                r_x[i] <= '0;
            end
            r_bias   <= '0;
            r_w_ptr  <= '0;
            r_x_ptr  <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sat    <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    // Commands are only honoured while idle
                    if (w_cmd) begin
                        case (w_op)
                            c_OP_LOAD_W: begin
                                r_w[r_w_ptr] <= ui_in;
                                r_w_ptr      <= (r_w_ptr == c_LAST) ? '0 : r_w_ptr + 1'b1;
                            end
                            c_OP_LOAD_X: begin
                                r_x[r_x_ptr] <= ui_in;
                                r_x_ptr      <= (r_x_ptr == c_LAST) ? '0 : r_x_ptr + 1'b1;
                            end
                            c_OP_LOAD_B: begin
                                r_bias <= ui_in;
                            end
                            c_OP_START: begin
                                r_acc   <= w_acc_init;
                                r_idx   <= '0;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                                r_sat   <= 1'b0;
                                r_state <= S_MAC;
                            end
                            c_OP_CLEAR_PTR: begin
                                r_w_ptr <= '0;
                                r_x_ptr <= '0;
                                r_done  <= 1'b0;
                                r_sat   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_idx == c_LAST) begin
                        r_idx   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_OUT: begin
                    r_result <= w_final;
                    r_sat    <= w_hi | w_lo;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign uo_out  = r_result;
    assign uio_out = {1'b0, r_sat, r_done, r_busy, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
`default_nettype wire

// File: tb/tb_gregac_tiny_nn.sv
`default_nettype none
// ============================================================================
// Module      : tb_gregac_tiny_nn
// Description : Self-checking bench for gregac_tiny_nn. Directed and random
//               operand sets are scored against an arithmetic neuron model.
//               Honours TINY_NN_RELU_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gregac_tiny_nn;

    localparam int N     = 8;
    localparam int SHIFT = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    int mw [N];
    int mx [N];
    int mb;
    int wp;
    int xp;
    int m_y;
    int m_done;
    int m_sat;

    gregac_tiny_nn #(.N(N), .SHIFT(SHIFT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            mw[i] = 0;
            mx[i] = 0;
        end
        mb = 0; wp = 0; xp = 0;
        m_y = 0; m_done = 0; m_sat = 0;
    endfunction

    // Neuron output from the model's operands, using plain integer math
    function automatic void model_compute(output int y, output int s);
        int acc;
        int t;
        acc = mb * (1 << SHIFT);
        for (int i = 0; i < N; i++) acc += mw[i] * mx[i];
        t = acc >>> SHIFT;
        s = 0;
        if (t > 127)  begin t = 127;  s = 1; end
        if (t < -128) begin t = -128; s = 1; end
`ifdef TINY_NN_RELU_EN
        if (t < 0) t = 0;
`endif
        y = t;
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] ey;
        ey = m_y;
        check({tag, ":uo_out"}, uo_out, ey[7:0]);
        check({tag, ":flags"}, {uio_out[6], uio_out[5], uio_out[4]},
              {m_sat[0], m_done[0], 1'b0});
    endtask

    // One command issued while the DUT is idle; the model follows it
    task automatic cmd(input logic [2:0] op, input logic [7:0] d);
        @(negedge clk);
        ena    = 1'b1;
        ui_in  = d;
        uio_in = {4'b0000, 1'b1, op};
        @(negedge clk);
        uio_in = 8'h00;
        case (op)
            3'd1: begin mw[wp] = int'($signed(d)); wp = (wp + 1) % N; end
            3'd2: begin mx[xp] = int'($signed(d)); xp = (xp + 1) % N; end
            3'd3: mb = int'($signed(d));
            3'd5: begin wp = 0; xp = 0; m_done = 0; m_sat = 0; end
            default: ;
        endcase
    endtask

    // START, then track exact latency; optional freeze and busy-time command
    task automatic run(input string tag, input int freeze_at,
                       input int busy_cmd_at, input logic [2:0] busy_op);
        int ey;
        int es;
        model_compute(ey, es);
        cmd(3'd4, 8'h00);
        check({tag, ":started"}, {uio_out[5], uio_out[4]}, 2'b01);
        for (int k = 1; k <= N + 1; k++) begin
            if (k == freeze_at) begin
                ena = 1'b0;
                repeat (4) @(negedge clk);
                check({tag, ":frozen"}, {uio_out[5], uio_out[4]}, 2'b01);
                ena = 1'b1;
            end
            if (k == busy_cmd_at) begin
                ui_in  = 8'h5A;
                uio_in = {4'b0000, 1'b1, busy_op};
            end
            @(negedge clk);
            uio_in = 8'h00;
            if (k <= N) check({tag, ":latency"}, {uio_out[5], uio_out[4]}, 2'b01);
        end
        m_y = ey; m_sat = es; m_done = 1;
        check_status(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset:uo_out", uo_out, 8'h00);
        check("reset:uio_out", uio_out, 8'h00);
        check("reset:uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;

        // Unit weights, inputs 1..8, zero bias -> 36 >>> 4 = 2
        cmd(3'd5, 8'h00);
        for (int i = 0; i < N; i++) cmd(3'd1, 8'd1);
        for (int i = 0; i < N; i++) cmd(3'd2, 8'(i + 1));
        cmd(3'd3, 8'h00);
        run("unit", 0, 0, 3'd0);
        check("unit:const", uo_out, 8'd2);

        // Full-scale positive saturation
        for (int i = 0; i < N; i++) cmd(3'd1, 8'd127);
        for (int i = 0; i < N; i++) cmd(3'd2, 8'd127);
        run("satpos", 0, 0, 3'd0);
        check("satpos:const", {uio_out[6], uo_out}, {1'b1, 8'd127});

        // CLEAR_PTR drops done and sat, result is held
        cmd(3'd5, 8'h00);
        check_status("clrptr");

        // Negative weights -> -5, or 0 with ReLU
        for (int i = 0; i < N; i++) cmd(3'd1, 8'hFF);
        for (int i = 0; i < N; i++) cmd(3'd2, 8'd10);
        run("neg", 0, 0, 3'd0);
`ifdef TINY_NN_RELU_EN
        check("neg:const", uo_out, 8'h00);
`else
        check("neg:const", uo_out, 8'hFB);
`endif

        // Zero weights, bias 16 -> 16; START during busy is ignored
        for (int i = 0; i < N; i++) cmd(3'd1, 8'd0);
        cmd(3'd3, 8'd16);
        run("bias", 0, 3, 3'd4);
        check("bias:const", uo_out, 8'd16);

        // LOAD_W during busy ignored, ena low mid-compute freezes it
        run("freeze", 5, 2, 3'd1);

        // Nine weights: the ninth overwrites w[0]; CLEAR_PTR while busy ignored
        cmd(3'd5, 8'h00);
        for (int i = 0; i < N + 1; i++) cmd(3'd1, 8'(i + 1));
        run("wrap", 0, 4, 3'd5);

        // A command with ena low must not land
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'd77;
        uio_in = {4'b0000, 1'b1, 3'd1};
        @(negedge clk);
        uio_in = 8'h00;
        ena    = 1'b1;
        cmd(3'd1, 8'd3);
        run("ena_off", 0, 0, 3'd0);

        // Asynchronous reset in the middle of the MAC
        cmd(3'd4, 8'h00);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("midrst:uo_out", uo_out, 8'h00);
        check("midrst:uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run("postrst", 0, 0, 3'd0);

        // Random operand sets with random extra loads to walk the pointers
        for (int it = 0; it < 10; it++) begin
            int extra;
            extra = int'($urandom_range(0, 3));
            for (int i = 0; i < N + extra; i++) cmd(3'd1, 8'($urandom));
            for (int i = 0; i < N; i++) cmd(3'd2, 8'($urandom));
            cmd(3'd3, 8'($urandom));
            run("random", (it % 3 == 0) ? 4 : 0, 0, 3'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
